// File: rtl/rs_issue_scheduler.sv
// ---------------------------------------------------------------------------
// rs_issue_scheduler
//
// Issue scheduler sitting between the reservation station (RS) table and the
// functional units. Every cycle it may load one ready RS entry into each of
// three issue slots (ALU, MEM, MULT), each slot with its own round-robin
// pointer. A slot presents its grant with valid/idx and holds it until the
// unit takes it. issue_ack tells the RS which entries were taken this cycle so
// the RS can mark them issued. The non-pipelined multiplier is modelled by an
// occupancy counter that keeps the MULT slot empty for MULT_LAT-1 cycles after
// each multiplier accept.
//
// Handshake (all three ports): a grant is offered while *_valid_o=1. It is
// taken in a cycle where *_valid_o=1 and *_ready_i=1 (and flush_i=0); in that
// cycle issue_ack_o[*_idx_o]=1. While valid=1 and ready=0 the grant (valid and
// idx) is held stable and req_i is ignored for that port. A slot that is empty
// or being taken may load a new pick at the same edge; picks are registered,
// so a request seen at edge t shows up on *_valid_o after edge t.
//
// Ports
//   clock_i        system clock
//   reset_i        synchronous active-high reset (wins over flush_i)
//   flush_i        squash: clears all grants and the multiplier counter
//   req_i          entry i busy, not issued, operands ready
//   cls_i          entry i class at [2i+1:2i]: 0 ALU, 1 LOAD, 2 STORE, 3 MULT
//   alu_ready_i    ALU accepts this cycle
//   mem_ready_i    MEM unit accepts this cycle
//   mult_ready_i   multiplier accepts this cycle
//   alu_valid_o    ALU grant held
//   alu_idx_o      RS index granted to ALU
//   mem_valid_o    MEM grant held
//   mem_idx_o      RS index granted to MEM
//   mult_valid_o   MULT grant held
//   mult_idx_o     RS index granted to MULT
//   issue_ack_o    entries accepted this cycle (combinational)
//   mult_busy_o    multiplier occupancy counter nonzero
// ---------------------------------------------------------------------------
module rs_issue_scheduler #(
    parameter int RS_SZ    = 5,
    parameter int IDX_W    = 3,
    parameter int MULT_LAT = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               flush_i,
    input  logic [RS_SZ-1:0]   req_i,
    input  logic [2*RS_SZ-1:0] cls_i,
    input  logic               alu_ready_i,
    input  logic               mem_ready_i,
    input  logic               mult_ready_i,
    output logic               alu_valid_o,
    output logic [IDX_W-1:0]   alu_idx_o,
    output logic               mem_valid_o,
    output logic [IDX_W-1:0]   mem_idx_o,
    output logic               mult_valid_o,
    output logic [IDX_W-1:0]   mult_idx_o,
    output logic [RS_SZ-1:0]   issue_ack_o,
    output logic               mult_busy_o
);

    localparam int NPORT     = 3;
    localparam int PORT_ALU  = 0;
    localparam int PORT_MEM  = 1;
    localparam int PORT_MULT = 2;

    // Counter holds values up to MULT_LAT-1.
    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LAT - 1);

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [NPORT-1:0] valid_q, valid_d;
    logic [IDX_W-1:0] idx_q [NPORT];
    logic [IDX_W-1:0] idx_d [NPORT];
    logic [IDX_W-1:0] ptr_q [NPORT];
    logic [IDX_W-1:0] ptr_d [NPORT];
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // -----------------------------------------------------------------------
    // Helpers
    // -----------------------------------------------------------------------

    // (v + 1) mod RS_SZ for an index that is always below RS_SZ.
    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] v);
        if (int'(v) >= RS_SZ - 1) begin
            return '0;
        end
        return v + IDX_W'(1);
    endfunction

    // Round-robin pick: first set bit of cand scanning start, start+1, ...
    // with wrap at RS_SZ. Returns {found, index}. The scan runs from the far
    // end back toward start so the nearest candidate is the last one written.
    function automatic logic [IDX_W:0] rr_pick(input logic [RS_SZ-1:0] cand,
                                               input logic [IDX_W-1:0] start);
        logic [IDX_W:0] res;
        int             j;
        res = '0;
        for (int k = RS_SZ - 1; k >= 0; k--) begin
            j = int'(start) + k;
            if (j >= RS_SZ) begin
                j = j - RS_SZ;
            end
            if (cand[j]) begin
                res = {1'b1, IDX_W'(j)};
            end
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // Class decode: which entries each port may ever take.
    // -----------------------------------------------------------------------
    logic [RS_SZ-1:0] elig [NPORT];

    always_comb begin
        logic [1:0] c;
        for (int p = 0; p < NPORT; p++) begin
            elig[p] = '0;
        end
        c = 2'd0;
        for (int i = 0; i < RS_SZ; i++) begin
            c = cls_i[2*i +: 2];
            elig[PORT_ALU][i]  = (c == 2'd0);
            elig[PORT_MEM][i]  = (c == 2'd1) || (c == 2'd2);
            elig[PORT_MULT][i] = (c == 2'd3);
        end
    end

    // -----------------------------------------------------------------------
    // Held entries, accepts and the ack vector.
    // An entry held by any valid slot (including one being accepted right
    // now) is never a candidate, so nothing is granted twice while the RS is
    // still catching up on the ack.
    // -----------------------------------------------------------------------
    logic [NPORT-1:0] ready;
    logic [NPORT-1:0] accept;
    logic [RS_SZ-1:0] held;
    logic [RS_SZ-1:0] ack;

    assign ready  = {mult_ready_i, mem_ready_i, alu_ready_i};
    assign accept = valid_q & ready & {NPORT{~flush_i}};

    always_comb begin
        held = '0;
        ack  = '0;
        for (int p = 0; p < NPORT; p++) begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (valid_q[p] && (idx_q[p] == IDX_W'(i))) begin
                    held[i] = 1'b1;
                    if (accept[p]) begin
                        ack[i] = 1'b1;
                    end
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Multiplier occupancy counter.
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d = cnt_q;
        if (flush_i) begin
            cnt_d = '0;
        end else if (accept[PORT_MULT]) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // -----------------------------------------------------------------------
    // Per-port slot next state.
    // The pointer moves past an accepted index, and the reload in the same
    // cycle already scans from the moved pointer. The MULT slot additionally
    // waits until the occupancy counter has drained.
    // -----------------------------------------------------------------------
    always_comb begin
        logic [RS_SZ-1:0] cand;
        logic [IDX_W:0]   pick;
        logic             slot_free;
        logic             may_load;

        cand      = '0;
        pick      = '0;
        slot_free = 1'b0;
        may_load  = 1'b0;
        valid_d   = valid_q;
        for (int p = 0; p < NPORT; p++) begin
            idx_d[p] = idx_q[p];
            ptr_d[p] = ptr_q[p];
        end

        for (int p = 0; p < NPORT; p++) begin
            cand      = req_i & elig[p] & ~held;
            ptr_d[p]  = accept[p] ? wrap_inc(idx_q[p]) : ptr_q[p];
            pick      = rr_pick(cand, ptr_d[p]);
            slot_free = !valid_q[p] || accept[p];
            may_load  = slot_free && !flush_i &&
                        ((p != PORT_MULT) || (cnt_d == '0));

            if (flush_i) begin
                valid_d[p] = 1'b0;
            end else if (slot_free) begin
                valid_d[p] = may_load && pick[IDX_W];
                if (may_load && pick[IDX_W]) begin
                    idx_d[p] = pick[IDX_W-1:0];
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int p = 0; p < NPORT; p++) begin
                idx_q[p] <= '0;
                ptr_q[p] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            for (int p = 0; p < NPORT; p++) begin
                idx_q[p] <= idx_d[p];
                ptr_q[p] <= ptr_d[p];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign alu_valid_o  = valid_q[PORT_ALU];
    assign alu_idx_o    = idx_q[PORT_ALU];
    assign mem_valid_o  = valid_q[PORT_MEM];
    assign mem_idx_o    = idx_q[PORT_MEM];
    assign mult_valid_o = valid_q[PORT_MULT];
    assign mult_idx_o   = idx_q[PORT_MULT];
    assign issue_ack_o  = ack;
    assign mult_busy_o  = (cnt_q != '0);

    // -----------------------------------------------------------------------
    // Invariants: granted indices exist, and no entry sits in two slots.
    // -----------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            for (int p = 0; p < NPORT; p++) begin
                assert (!valid_q[p] || (int'(idx_q[p]) < RS_SZ));
                for (int r = p + 1; r < NPORT; r++) begin
                    assert (!(valid_q[p] && valid_q[r] && (idx_q[p] == idx_q[r])));
                end
            end
        end
    end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
module tb_rs_issue_scheduler;

  localparam int RS_SZ    = 5;
  localparam int IDX_W    = 3;
  localparam int MULT_LAT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst;
  logic               flush;
  logic [RS_SZ-1:0]   req;
  logic [2*RS_SZ-1:0] cls;
  logic               alu_rdy, mem_rdy, mult_rdy;
  logic               alu_valid, mem_valid, mult_valid;
  logic [IDX_W-1:0]   alu_idx, mem_idx, mult_idx;
  logic [RS_SZ-1:0]   issue_ack;
  logic               mult_busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  rs_issue_scheduler #(
    .RS_SZ    (RS_SZ),
    .IDX_W    (IDX_W),
    .MULT_LAT (MULT_LAT)
  ) dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .flush_i      (flush),
    .req_i        (req),
    .cls_i        (cls),
    .alu_ready_i  (alu_rdy),
    .mem_ready_i  (mem_rdy),
    .mult_ready_i (mult_rdy),
    .alu_valid_o  (alu_valid),
    .alu_idx_o    (alu_idx),
    .mem_valid_o  (mem_valid),
    .mem_idx_o    (mem_idx),
    .mult_valid_o (mult_valid),
    .mult_idx_o   (mult_idx),
    .issue_ack_o  (issue_ack),
    .mult_busy_o  (mult_busy)
  );

  // ---------------- reference model ----------------
  // Each port is a slot holding at most one entry number; a pointer per port
  // says where the round-robin search starts; m_cnt counts remaining busy
  // cycles of the multiplier.
  int m_v[3];
  int m_i[3];
  int m_p[3];
  int m_cnt;

  function automatic int port_of(input logic [1:0] c);
    if (c == 2'd0) return 0;
    if (c == 2'd3) return 2;
    return 1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_v[p] = 0; m_i[p] = 0; m_p[p] = 0;
    end
    m_cnt = 0;
  endtask

  function automatic logic [RS_SZ-1:0] model_ack();
    logic [RS_SZ-1:0] a;
    int rd[3];
    rd = '{int'(alu_rdy), int'(mem_rdy), int'(mult_rdy)};
    a = '0;
    for (int p = 0; p < 3; p++)
      if (m_v[p] != 0 && rd[p] != 0 && !flush) a[m_i[p]] = 1'b1;
    return a;
  endfunction

  task automatic model_step();
    int rd[3];
    int acc[3];
    int held[RS_SZ];
    int new_cnt;
    int j;
    if (rst) begin
      model_reset();
      return;
    end
    rd = '{int'(alu_rdy), int'(mem_rdy), int'(mult_rdy)};
    for (int i = 0; i < RS_SZ; i++) held[i] = 0;
    for (int p = 0; p < 3; p++) if (m_v[p] != 0) held[m_i[p]] = 1;
    for (int p = 0; p < 3; p++) acc[p] = (m_v[p] != 0 && rd[p] != 0 && !flush) ? 1 : 0;
    if (flush) new_cnt = 0;
    else if (acc[2] != 0) new_cnt = MULT_LAT - 1;
    else if (m_cnt > 0) new_cnt = m_cnt - 1;
    else new_cnt = 0;
    m_cnt = new_cnt;
    for (int p = 0; p < 3; p++) begin
      if (acc[p] != 0) m_p[p] = (m_i[p] + 1) % RS_SZ;
      if (flush) begin
        m_v[p] = 0;
      end else if (m_v[p] == 0 || acc[p] != 0) begin
        m_v[p] = 0;
        if (p != 2 || new_cnt == 0) begin
          for (int k = 0; k < RS_SZ; k++) begin
            j = (m_p[p] + k) % RS_SZ;
            if (m_v[p] == 0 && req[j] && port_of(cls[2*j +: 2]) == p && held[j] == 0) begin
              m_v[p] = 1;
              m_i[p] = j;
            end
          end
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; req = '0; cls = '0;
    alu_rdy = 1'b0; mem_rdy = 1'b0; mult_rdy = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req = 5'b11111; cls = 10'b11_10_01_00_00;
    alu_rdy = 1'b1; mem_rdy = 1'b1; mult_rdy = 1'b1;
    tick(); tick();
    #1;
    total_cnt++; if ({alu_valid, mem_valid, mult_valid} !== 3'b000) $display("FAIL reset_valid: got %b want 000", {alu_valid, mem_valid, mult_valid}); else pass_cnt++;
    total_cnt++; if ({alu_idx, mem_idx, mult_idx} !== 9'd0) $display("FAIL reset_idx: got %h want 0", {alu_idx, mem_idx, mult_idx}); else pass_cnt++;
    total_cnt++; if (mult_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", mult_busy); else pass_cnt++;
    total_cnt++; if (issue_ack !== 5'b00000) $display("FAIL reset_ack: got %b want 00000", issue_ack); else pass_cnt++;
    rst = 1'b0; req = '0; cls = '0; alu_rdy = 1'b0; mem_rdy = 1'b0; mult_rdy = 1'b0;
  endtask

  task automatic test_alu_basic();
    do_reset();
    req = 5'b00110; cls = '0; alu_rdy = 1'b0;
    tick(); #1;
    total_cnt++; if (alu_valid !== 1'b1 || alu_idx !== 3'd1) $display("FAIL alu_first: got v=%b idx=%0d want v=1 idx=1", alu_valid, alu_idx); else pass_cnt++;
    alu_rdy = 1'b1; #1;
    total_cnt++; if (issue_ack !== 5'b00010) $display("FAIL alu_ack1: got %b want 00010", issue_ack); else pass_cnt++;
    tick(); req = 5'b00100; #1;
    total_cnt++; if (alu_valid !== 1'b1 || alu_idx !== 3'd2) $display("FAIL alu_second: got v=%b idx=%0d want v=1 idx=2", alu_valid, alu_idx); else pass_cnt++;
    total_cnt++; if (issue_ack !== 5'b00100) $display("FAIL alu_ack2: got %b want 00100", issue_ack); else pass_cnt++;
    tick(); req = 5'b00000; #1;
    total_cnt++; if (alu_valid !== 1'b0) $display("FAIL alu_drain: got v=%b want 0", alu_valid); else pass_cnt++;
    // pointer now sits at 3: with everyone requesting, 3 must win
    req = 5'b11111; alu_rdy = 1'b0;
    tick(); #1;
    total_cnt++; if (alu_valid !== 1'b1 || alu_idx !== 3'd3) $display("FAIL alu_ptr3: got v=%b idx=%0d want v=1 idx=3", alu_valid, alu_idx); else pass_cnt++;
  endtask

  // Runs straight after test_alu_basic: entry 3 is held on ALU.
  task automatic test_hold();
    for (int c = 0; c < 3; c++) begin
      req = 5'($urandom_range(0, 31)); alu_rdy = 1'b0; #1;
      total_cnt++; if (alu_valid !== 1'b1 || alu_idx !== 3'd3) $display("FAIL hold_idx%0d: got v=%b idx=%0d want v=1 idx=3", c, alu_valid, alu_idx); else pass_cnt++;
      total_cnt++; if (issue_ack !== 5'b00000) $display("FAIL hold_ack%0d: got %b want 00000", c, issue_ack); else pass_cnt++;
      tick();
    end
    req = 5'b01000; alu_rdy = 1'b1; #1;
    total_cnt++; if (issue_ack !== 5'b01000) $display("FAIL hold_release: got %b want 01000", issue_ack); else pass_cnt++;
    tick(); req = 5'b00000; #1;
    total_cnt++; if (alu_valid !== 1'b0 || issue_ack !== 5'b00000) $display("FAIL hold_no_dup: got v=%b ack=%b want v=0 ack=00000", alu_valid, issue_ack); else pass_cnt++;
  endtask

  task automatic test_mult();
    do_reset();
    cls = 10'b11_11_00_00_00; req = 5'b11000; mult_rdy = 1'b1;
    tick(); #1;
    total_cnt++; if (mult_valid !== 1'b1 || mult_idx !== 3'd3 || issue_ack !== 5'b01000) $display("FAIL mult_first: got v=%b idx=%0d ack=%b want v=1 idx=3 ack=01000", mult_valid, mult_idx, issue_ack); else pass_cnt++;
    tick(); req = 5'b10000;
    for (int c = 1; c <= 3; c++) begin
      #1;
      total_cnt++; if (mult_busy !== 1'b1 || mult_valid !== 1'b0 || issue_ack !== 5'b00000) $display("FAIL mult_busy_t%0d: got busy=%b v=%b ack=%b want busy=1 v=0 ack=00000", c, mult_busy, mult_valid, issue_ack); else pass_cnt++;
      tick();
    end
    #1;
    total_cnt++; if (mult_valid !== 1'b1 || mult_idx !== 3'd4 || mult_busy !== 1'b0) $display("FAIL mult_second: got v=%b idx=%0d busy=%b want v=1 idx=4 busy=0", mult_valid, mult_idx, mult_busy); else pass_cnt++;
    total_cnt++; if (issue_ack !== 5'b10000) $display("FAIL mult_ack2: got %b want 10000", issue_ack); else pass_cnt++;
    tick(); req = 5'b00000; #1;
    total_cnt++; if (mult_busy !== 1'b1) $display("FAIL mult_rebusy: got %b want 1", mult_busy); else pass_cnt++;
  endtask

  task automatic test_rr_fair();
    int exp_order[6];
    exp_order = '{0, 1, 2, 0, 1, 2};
    do_reset();
    cls = '0; req = 5'b00111; alu_rdy = 1'b1;
    tick();
    for (int n = 0; n < 6; n++) begin
      #1;
      total_cnt++; if (alu_valid !== 1'b1 || int'(alu_idx) != exp_order[n]) $display("FAIL rr_grant%0d: got v=%b idx=%0d want v=1 idx=%0d", n, alu_valid, alu_idx, exp_order[n]); else pass_cnt++;
      total_cnt++; if (issue_ack !== 5'(1 << exp_order[n])) $display("FAIL rr_ack%0d: got %b want %b", n, issue_ack, 5'(1 << exp_order[n])); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_mixed();
    do_reset();
    cls = 10'b11_00_10_00_01; req = 5'b10111;
    tick(); #1;
    total_cnt++; if (mem_valid !== 1'b1 || mem_idx !== 3'd0) $display("FAIL mix_mem: got v=%b idx=%0d want v=1 idx=0", mem_valid, mem_idx); else pass_cnt++;
    total_cnt++; if (alu_valid !== 1'b1 || alu_idx !== 3'd1) $display("FAIL mix_alu: got v=%b idx=%0d want v=1 idx=1", alu_valid, alu_idx); else pass_cnt++;
    total_cnt++; if (mult_valid !== 1'b1 || mult_idx !== 3'd4) $display("FAIL mix_mult: got v=%b idx=%0d want v=1 idx=4", mult_valid, mult_idx); else pass_cnt++;
    alu_rdy = 1'b1; mem_rdy = 1'b1; mult_rdy = 1'b1; #1;
    total_cnt++; if (issue_ack !== 5'b10011) $display("FAIL mix_ack: got %b want 10011", issue_ack); else pass_cnt++;
    tick(); req = 5'b00100; alu_rdy = 1'b0; mem_rdy = 1'b0; mult_rdy = 1'b0; #1;
    total_cnt++; if (mem_valid !== 1'b1 || mem_idx !== 3'd2) $display("FAIL mix_mem_next: got v=%b idx=%0d want v=1 idx=2", mem_valid, mem_idx); else pass_cnt++;
    total_cnt++; if (alu_valid !== 1'b0 || mult_valid !== 1'b0 || mult_busy !== 1'b1) $display("FAIL mix_after: got alu=%b mult=%b busy=%b want 0 0 1", alu_valid, mult_valid, mult_busy); else pass_cnt++;
  endtask

  task automatic test_flush();
    do_reset();
    cls = 10'b11_00_10_00_00; req = 5'b10100; mult_rdy = 1'b1; mem_rdy = 1'b0;
    tick(); req = 5'b00100;
    tick(); tick(); #1;
    total_cnt++; if (mem_valid !== 1'b1 || mem_idx !== 3'd2 || mult_busy !== 1'b1) $display("FAIL flush_setup: got v=%b idx=%0d busy=%b want 1 2 1", mem_valid, mem_idx, mult_busy); else pass_cnt++;
    flush = 1'b1; mem_rdy = 1'b1; #1;
    total_cnt++; if (issue_ack !== 5'b00000) $display("FAIL flush_ack: got %b want 00000", issue_ack); else pass_cnt++;
    tick(); flush = 1'b0; #1;
    total_cnt++; if ({alu_valid, mem_valid, mult_valid, mult_busy} !== 4'b0000) $display("FAIL flush_clear: got %b want 0000", {alu_valid, mem_valid, mult_valid, mult_busy}); else pass_cnt++;
    total_cnt++; if (issue_ack !== 5'b00000) $display("FAIL flush_after_ack: got %b want 00000", issue_ack); else pass_cnt++;
    mem_rdy = 1'b0;
    tick(); #1;
    total_cnt++; if (mem_valid !== 1'b1 || mem_idx !== 3'd2) $display("FAIL flush_resume: got v=%b idx=%0d want v=1 idx=2", mem_valid, mem_idx); else pass_cnt++;
  endtask

  // Runs straight after test_flush: entry 2 is held on MEM.
  task automatic test_reset_hold();
    tick(); #1;
    total_cnt++; if (mem_valid !== 1'b1) $display("FAIL rsthold_pre: got v=%b want 1", mem_valid); else pass_cnt++;
    rst = 1'b1;
    tick(); #1;
    total_cnt++; if ({alu_valid, mem_valid, mult_valid, mult_busy} !== 4'b0000 || {alu_idx, mem_idx, mult_idx} !== 9'd0) $display("FAIL rsthold_clear: got v=%b idx=%h want 0", {alu_valid, mem_valid, mult_valid, mult_busy}, {alu_idx, mem_idx, mult_idx}); else pass_cnt++;
    rst = 1'b0; req = '0;
  endtask

  task automatic test_random();
    logic             dv[3];
    logic [IDX_W-1:0] di[3];
    logic [RS_SZ-1:0] ea;
    do_reset();
    model_reset();
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 63) == 0);
      flush    = ($urandom_range(0, 19) == 0);
      req      = 5'($urandom_range(0, 31));
      cls      = 10'($urandom_range(0, 1023));
      alu_rdy  = ($urandom_range(0, 3) != 0);
      mem_rdy  = ($urandom_range(0, 3) != 0);
      mult_rdy = ($urandom_range(0, 3) != 0);
      #1;
      dv = '{alu_valid, mem_valid, mult_valid};
      di = '{alu_idx, mem_idx, mult_idx};
      for (int p = 0; p < 3; p++) begin
        total_cnt++; if (int'(dv[p]) != m_v[p]) $display("FAIL rnd_valid c%0d p%0d: got %b want %0d", c, p, dv[p], m_v[p]); else pass_cnt++;
        if (m_v[p] != 0) begin
          total_cnt++; if (int'(di[p]) != m_i[p]) $display("FAIL rnd_idx c%0d p%0d: got %0d want %0d", c, p, di[p], m_i[p]); else pass_cnt++;
        end
      end
      ea = model_ack();
      total_cnt++; if (issue_ack !== ea) $display("FAIL rnd_ack c%0d: got %b want %b", c, issue_ack, ea); else pass_cnt++;
      total_cnt++; if (mult_busy !== (m_cnt != 0)) $display("FAIL rnd_busy c%0d: got %b want %b", c, mult_busy, (m_cnt != 0)); else pass_cnt++;
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    rst = 1'b1; flush = 1'b0; req = '0; cls = '0;
    alu_rdy = 1'b0; mem_rdy = 1'b0; mult_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_alu_basic();
    test_hold();
    test_mult();
    test_rr_fair();
    test_mixed();
    test_flush();
    test_reset_hold();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
